// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one Wishbone-style memory port between instruction
// fetch (I) and load/store (D).
//  - Fixed D-over-I priority from IDLE.
//  - Zero-bubble hand-over to the other requester on completion. Because of
//    this, a pending fetch is always served after a data transfer.
//  - Bus outputs are registered; requester acks and read data pass through
//    combinationally from the bus.
// Optional feature macro: RV_ARB_TIMEOUT_EN. When it is defined, a transfer
// that gets no bus ack within TIMEOUT_CYC cycles is aborted with o_err.
module rv_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_ib_req,
  input  logic [ADDR_W-1:0]   i_ib_adr,
  output logic                o_ib_ack,
  output logic [DATA_W-1:0]   o_ib_dat,
  input  logic                i_db_req,
  input  logic                i_db_we,
  input  logic [ADDR_W-1:0]   i_db_adr,
  input  logic [DATA_W/8-1:0] i_db_sel,
  input  logic [DATA_W-1:0]   i_db_dat,
  output logic                o_db_ack,
  output logic [DATA_W-1:0]   o_db_dat,
  output logic                o_err,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic                o_wb_we,
  output logic [ADDR_W-1:0]   o_wb_adr,
  output logic [DATA_W/8-1:0] o_wb_sel,
  output logic [DATA_W-1:0]   o_wb_dat,
  input  logic                i_wb_ack,
  input  logic [DATA_W-1:0]   i_wb_dat
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_BUS_I, S_BUS_D} state_t;

  state_t              r_state, w_next;
  logic                r_cyc, r_we;
  logic [ADDR_W-1:0]   r_adr;
  logic [SEL_W-1:0]    r_sel;
  logic [DATA_W-1:0]   r_dat;

  logic                w_timeout, w_done, w_grant_i, w_grant_d;
  logic                w_ib_ack, w_db_ack, w_err;
  logic [DATA_W-1:0]   w_ib_dat, w_db_dat;

`ifdef RV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;

  // A stalled slave is abandoned once the cycle count hits the limit.
  // A real ack arriving in that same cycle still wins over the abort.
  assign w_timeout = (r_state != S_IDLE) && !i_wb_ack &&
                     (r_cnt == CNT_W'(TIMEOUT_CYC));

  // Cycles spent in the current bus transfer; restarts on every grant.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                  r_cnt <= '0;
    else if (w_grant_i || w_grant_d) r_cnt <= '0;
    else if (r_state != S_IDLE)      r_cnt <= r_cnt + CNT_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and requester responses: finish the current owner, then
  // hand the bus straight to the other side if it is waiting.
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_ib_ack  = 1'b0;
    w_db_ack  = 1'b0;
    w_ib_dat  = '0;
    w_db_dat  = '0;
    w_done    = (r_state != S_IDLE) && (i_wb_ack || w_timeout);
    w_err     = w_done && !i_wb_ack;
    case (r_state)
      S_IDLE: begin
        if (i_db_req)      w_grant_d = 1'b1;
        else if (i_ib_req) w_grant_i = 1'b1;
      end
      S_BUS_I: begin
        if (w_done) begin
          w_ib_ack = 1'b1;
          w_ib_dat = i_wb_ack ? i_wb_dat : '0;
          if (i_db_req) w_grant_d = 1'b1;
          else          w_next    = S_IDLE;
        end
      end
      S_BUS_D: begin
        if (w_done) begin
          w_db_ack = 1'b1;
          w_db_dat = i_wb_ack ? i_wb_dat : '0;
          if (i_ib_req) w_grant_i = 1'b1;
          else          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_grant_d) w_next = S_BUS_D;
    if (w_grant_i) w_next = S_BUS_I;
  end

  // State and registered bus outputs.
  // Address and controls are captured only on a grant edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_sel   <= '0;
      r_dat   <= '0;
    end else begin
      r_state <= w_next;
      r_cyc   <= (w_next != S_IDLE);
      if (w_grant_d) begin
        r_we  <= i_db_we;
        r_adr <= i_db_adr;
        r_sel <= i_db_sel;
        r_dat <= i_db_dat;
      end else if (w_grant_i) begin
        // Fetch is always a full-word read.
        r_we  <= 1'b0;
        r_adr <= i_ib_adr;
        r_sel <= '1;
        r_dat <= '0;
      end else if (w_next == S_IDLE) begin
        r_we  <= 1'b0;
      end
    end
  end

  assign o_wb_cyc = r_cyc;
  assign o_wb_stb = r_cyc;
  assign o_wb_we  = r_we;
  assign o_wb_adr = r_adr;
  assign o_wb_sel = r_sel;
  assign o_wb_dat = r_dat;
  assign o_ib_ack = w_ib_ack;
  assign o_ib_dat = w_ib_dat;
  assign o_db_ack = w_db_ack;
  assign o_db_dat = w_db_dat;
`ifdef RV_ARB_TIMEOUT_EN
  assign o_err    = w_err;
`else
  assign o_err    = 1'b0;
`endif

endmodule
